// File: rtl/stage_channel_scheduler.sv
// Launch/collect scheduler for NUM_CH channel workers of one decoder stage.
// Optional busy watchdog enabled by defining STAGE_WATCHDOG_EN.
module stage_channel_scheduler #(
  parameter int NUM_CH          = 2,
  parameter int SEQUENTIAL      = 0,
  parameter int WATCHDOG_CYCLES = 4096
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stage_ready,
  input  logic [NUM_CH-1:0] channel_mask,
  output logic [NUM_CH-1:0] channel_ready,
  input  logic [NUM_CH-1:0] channel_done,
  output logic              stage_busy,
  output logic              stage_done,
  output logic              stage_error,
  output logic              stage_timeout
);

  if (NUM_CH < 1 || NUM_CH > 8 || WATCHDOG_CYCLES < 2) begin : g_cfg_check
    $error("stage_channel_scheduler: NUM_CH must be 1..8 and WATCHDOG_CYCLES >= 2");
  end

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, FINISH} state_t;

  state_t            state;
  logic [NUM_CH-1:0] mask_q;
  logic [NUM_CH-1:0] pending_q;
  logic [NUM_CH-1:0] inflight_q;
  logic [NUM_CH-1:0] finished_q;

  logic [NUM_CH-1:0] first_launch;
  logic [NUM_CH-1:0] next_launch;
  logic [NUM_CH-1:0] accepted;
  logic [NUM_CH-1:0] inflight_n;
  logic              all_done;
  logic              protocol_err;

  function automatic logic [NUM_CH-1:0] lowest_bit(input logic [NUM_CH-1:0] v);
    return v & (~v + NUM_CH'(1));
  endfunction

  // A channel's done only counts from the cycle after its channel_ready pulse.
  always_comb begin
    first_launch = (SEQUENTIAL != 0) ? lowest_bit(channel_mask) : channel_mask;
    next_launch  = (SEQUENTIAL != 0) ? lowest_bit(pending_q) : pending_q;
    accepted     = channel_done & inflight_q & ~channel_ready;
    inflight_n   = inflight_q & ~accepted;
    all_done     = ((finished_q | accepted) == mask_q);
    protocol_err = (|(channel_done & ~accepted)) | (stage_ready && state != IDLE);
  end

`ifdef STAGE_WATCHDOG_EN
  localparam int WD_W = $clog2(WATCHDOG_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(WATCHDOG_CYCLES - 1);
  logic [WD_W-1:0] wd_cnt;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      mask_q        <= '0;
      pending_q     <= '0;
      inflight_q    <= '0;
      finished_q    <= '0;
      channel_ready <= '0;
      stage_busy    <= 1'b0;
      stage_done    <= 1'b0;
      stage_error   <= 1'b0;
      stage_timeout <= 1'b0;
`ifdef STAGE_WATCHDOG_EN
      wd_cnt        <= '0;
`endif
    end else begin
      channel_ready <= '0;
      stage_done    <= 1'b0;
      stage_error   <= protocol_err;
      stage_timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (stage_ready) begin
            mask_q     <= channel_mask;
            finished_q <= '0;
            if (channel_mask == '0) begin
              stage_done <= 1'b1;
              state      <= FINISH;
            end else begin
              channel_ready <= first_launch;
              inflight_q    <= first_launch;
              pending_q     <= channel_mask & ~first_launch;
              stage_busy    <= 1'b1;
              state         <= LAUNCH;
`ifdef STAGE_WATCHDOG_EN
              wd_cnt        <= '0;
`endif
            end
          end
        end
        LAUNCH, WAIT: begin
          inflight_q <= inflight_n;
          finished_q <= finished_q | accepted;
          if (state == LAUNCH) begin
            state <= WAIT;
          end else if (inflight_n == '0 && pending_q != '0) begin
            channel_ready <= next_launch;
            inflight_q    <= next_launch;
            pending_q     <= pending_q & ~next_launch;
            state         <= LAUNCH;
          end else if (all_done) begin
            stage_done <= 1'b1;
            stage_busy <= 1'b0;
            state      <= FINISH;
          end
`ifdef STAGE_WATCHDOG_EN
          wd_cnt <= wd_cnt + WD_W'(1);
          // Abort only if this cycle does not already complete the granule.
          if (wd_cnt == WD_LAST && !(state == WAIT && all_done)) begin
            stage_timeout <= 1'b1;
            stage_busy    <= 1'b0;
            channel_ready <= '0;
            mask_q        <= '0;
            pending_q     <= '0;
            inflight_q    <= '0;
            finished_q    <= '0;
            state         <= IDLE;
          end
`endif
        end
        FINISH: begin
          mask_q     <= '0;
          pending_q  <= '0;
          inflight_q <= '0;
          finished_q <= '0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_stage_channel_scheduler.sv
// Scoreboard bench: parallel 2-channel instance (a) and sequential 3-channel instance (b).
module tb_stage_channel_scheduler;
  logic       clk = 1'b0;
  logic       rst;
  logic       ready_a, busy_a, done_a, err_a, to_a;
  logic [1:0] mask_a, cready_a, cdone_a;
  logic       ready_b, busy_b, done_b, err_b, to_b;
  logic [2:0] mask_b, cready_b, cdone_b;

  localparam logic [10:0] EV_DONE = 11'h400;
  localparam logic [10:0] EV_ERR  = 11'h200;
  localparam logic [10:0] EV_TO   = 11'h100;

  stage_channel_scheduler #(.NUM_CH(2), .SEQUENTIAL(0), .WATCHDOG_CYCLES(16)) dut_a (
    .clk(clk), .rst(rst), .stage_ready(ready_a), .channel_mask(mask_a),
    .channel_ready(cready_a), .channel_done(cdone_a), .stage_busy(busy_a),
    .stage_done(done_a), .stage_error(err_a), .stage_timeout(to_a));

  stage_channel_scheduler #(.NUM_CH(3), .SEQUENTIAL(1), .WATCHDOG_CYCLES(16)) dut_b (
    .clk(clk), .rst(rst), .stage_ready(ready_b), .channel_mask(mask_b),
    .channel_ready(cready_b), .channel_done(cdone_b), .stage_busy(busy_b),
    .stage_done(done_b), .stage_error(err_b), .stage_timeout(to_b));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic [10:0] vec;
    string       name;
  } ev_t;

  ev_t q0[$];
  ev_t q1[$];
  int  n_vec = 0;
  int  n_miss = 0;
  bit  mon_en = 1'b0;

  task automatic push(input int d, input int c, input logic [10:0] v, input string nm);
    ev_t e;
    e.cyc = c; e.vec = v; e.name = nm;
    if (d == 0) q0.push_back(e);
    else q1.push_back(e);
  endtask

  task automatic check_obs(input int d, input logic [10:0] obs);
    ev_t e;
    bit  empty;
    n_vec++;
    empty = (d == 0) ? (q0.size() == 0) : (q1.size() == 0);
    if (empty) begin
      n_miss++;
      $display("FAIL unexpected_output dut%0d: got %h at cycle %0d, required no output", d, obs, cyc);
    end else begin
      if (d == 0) e = q0.pop_front();
      else e = q1.pop_front();
      if (e.cyc != cyc || e.vec !== obs) begin
        n_miss++;
        $display("FAIL %s: got %h at cycle %0d, required %h at cycle %0d", e.name, obs, cyc, e.vec, e.cyc);
      end
    end
  endtask

  task automatic check_lvl(input string nm, input logic [15:0] got, input logic [15:0] req);
    n_vec++;
    if (got !== req) begin
      n_miss++;
      $display("FAIL %s: got %h at cycle %0d, required %h", nm, got, cyc, req);
    end
  endtask

  // Monitor: any pulse output pops the next expected event for that instance.
  always @(negedge clk) begin
    logic [10:0] oa;
    logic [10:0] ob;
    if (mon_en) begin
      oa = {done_a, err_a, to_a, 6'b0, cready_a};
      ob = {done_b, err_b, to_b, 5'b0, cready_b};
      if (oa !== 11'h0) check_obs(0, oa);
      if (ob !== 11'h0) check_obs(1, ob);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    ready_a = 1'b0; cdone_a = '0;
    ready_b = 1'b0; cdone_b = '0;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) step();
  endtask

  initial begin
    #100000;
    $display("FAIL tb_time_limit: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "time limit");
  end

  initial begin
    int t;
    rst = 1'b1;
    ready_a = 1'b0; mask_a = '0; cdone_a = '0;
    ready_b = 1'b0; mask_b = '0; cdone_b = '0;
    repeat (3) step();
    check_lvl("reset_a", {11'b0, busy_a, done_a, err_a, to_a, |cready_a}, 16'h0);
    check_lvl("reset_b", {11'b0, busy_b, done_b, err_b, to_b, |cready_b}, 16'h0);
    rst = 1'b0;
    step();
    mon_en = 1'b1;

    // Parallel, both channels, staggered dones.
    step();
    t = cyc;
    ready_a = 1'b1; mask_a = 2'b11;
    push(0, t + 1, 11'h003, "t1_launch");
    step();
    check_lvl("t1_busy_start", {15'b0, busy_a}, 16'h1);
    wait_until(t + 5); cdone_a = 2'b01;
    wait_until(t + 9);
    check_lvl("t1_busy_end", {15'b0, busy_a}, 16'h1);
    cdone_a = 2'b10;
    push(0, t + 10, EV_DONE, "t1_done");
    wait_until(t + 10);
    check_lvl("t1_busy_drop", {15'b0, busy_a}, 16'h0);

    // Mono granule, then a stray done on the masked channel.
    step(); step();
    t = cyc;
    ready_a = 1'b1; mask_a = 2'b01;
    push(0, t + 1, 11'h001, "t2_launch");
    wait_until(t + 4); cdone_a = 2'b01;
    push(0, t + 5, EV_DONE, "t2_done");
    wait_until(t + 6); cdone_a = 2'b10;
    push(0, t + 7, EV_ERR, "t2_stray_err");
    wait_until(t + 8);

    // Empty mask, then stage_ready arriving in the FINISH cycle.
    step();
    t = cyc;
    ready_a = 1'b1; mask_a = 2'b00;
    push(0, t + 1, EV_DONE, "t4_done");
    step();
    check_lvl("t4_busy", {15'b0, busy_a}, 16'h0);
    ready_a = 1'b1; mask_a = 2'b11;
    push(0, t + 2, EV_ERR, "t4_ready_in_finish");
    step(); step();
    check_lvl("t4_no_launch", {15'b0, busy_a}, 16'h0);

    // Simultaneous dones; stage_ready during WAIT.
    step();
    t = cyc;
    ready_a = 1'b1; mask_a = 2'b11;
    push(0, t + 1, 11'h003, "t5_launch");
    wait_until(t + 3); ready_a = 1'b1; mask_a = 2'b11;
    push(0, t + 4, EV_ERR, "t5_ready_in_wait");
    wait_until(t + 5); cdone_a = 2'b11;
    push(0, t + 6, EV_DONE, "t5_done");
    wait_until(t + 8);

    // Reset while waiting: no completion afterwards.
    t = cyc;
    ready_a = 1'b1; mask_a = 2'b11;
    push(0, t + 1, 11'h003, "t6_launch");
    wait_until(t + 3); rst = 1'b1;
    step(); rst = 1'b0;
    check_lvl("t6_reset_out", {11'b0, busy_a, done_a, err_a, to_a, |cready_a}, 16'h0);
    wait_until(t + 8);

    // Worker never answers.
    t = cyc;
    ready_a = 1'b1; mask_a = 2'b01;
    push(0, t + 1, 11'h001, "wd_launch");
`ifdef STAGE_WATCHDOG_EN
    push(0, t + 17, EV_TO, "wd_timeout");
`endif
    wait_until(t + 20);
`ifdef STAGE_WATCHDOG_EN
    check_lvl("wd_busy", {15'b0, busy_a}, 16'h0);
`else
    check_lvl("wd_busy", {15'b0, busy_a}, 16'h1);
`endif
    rst = 1'b1;
    step(); rst = 1'b0;
    step();

    // Sequential 3-channel, mask 101, with a masked-channel done mid-granule.
    t = cyc;
    ready_b = 1'b1; mask_b = 3'b101;
    push(1, t + 1, 11'h001, "t3_launch0");
    wait_until(t + 4); cdone_b = 3'b001;
    push(1, t + 5, 11'h004, "t3_launch2");
    wait_until(t + 6); cdone_b = 3'b010;
    push(1, t + 7, EV_ERR, "t3_masked_done");
    wait_until(t + 8);
    check_lvl("t3_busy", {15'b0, busy_b}, 16'h1);
    cdone_b = 3'b100;
    push(1, t + 9, EV_DONE, "t3_done");
    wait_until(t + 9);
    check_lvl("t3_busy_drop", {15'b0, busy_b}, 16'h0);
    wait_until(t + 12);

    while (q0.size() != 0) begin
      ev_t e;
      e = q0.pop_front();
      n_vec++; n_miss++;
      $display("FAIL %s: got nothing, required %h at cycle %0d", e.name, e.vec, e.cyc);
    end
    while (q1.size() != 0) begin
      ev_t e;
      e = q1.pop_front();
      n_vec++; n_miss++;
      $display("FAIL %s: got nothing, required %h at cycle %0d", e.name, e.vec, e.cyc);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
